key_device: RTL and testbench

KEY_DEVICE -- requirements
Module: key_device

---
 rtl/key_device.sv | 114 +++++++++++
 tb/tb_key_device.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/key_device.sv
// Memory-mapped KEY port: synchronized, optionally debounced (KEY_DEBOUNCE_EN), with RDY/OR/IE status and interrupt.
// Without KEY_DEBOUNCE_EN, kdata follows the synchronized pins and DEBOUNCE_CYCLES is unused.
module key_device #(
  parameter int               DBITS           = 32,
  parameter logic [DBITS-1:0] ADDR_KDATA      = 32'hF0000010,
  parameter logic [DBITS-1:0] ADDR_KCTRL      = 32'hF0000110,
  parameter int               DEBOUNCE_CYCLES = 100000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [DBITS-1:0] abus,
  inout  wire  [DBITS-1:0] dbus,
  input  logic             we,
  input  logic [3:0]       key,
  output logic             intr
);

  logic [3:0]       sync1;
  logic [3:0]       sync2;
  logic [3:0]       kdata;
  logic             rdy;
  logic             ovr;
  logic             ie;
  logic             commit;
  logic             rd_kdata;
  logic             rd_kctrl;
  logic             wr_kctrl;
  logic [DBITS-1:0] rdata;
  logic             unused_bits;

  assign rd_kdata = (abus == ADDR_KDATA) && !we;
  assign rd_kctrl = (abus == ADDR_KCTRL) && !we;
  assign wr_kctrl = (abus == ADDR_KCTRL) && we;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1 <= 4'hF;
      sync2 <= 4'hF;
    end else begin
      sync1 <= key;
      sync2 <= sync1;
    end
  end

`ifdef KEY_DEBOUNCE_EN
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_inc;

  assign cnt_inc = cnt + CW'(1);
  assign commit  = (sync2 != kdata) && (cnt_inc == CW'(DEBOUNCE_CYCLES));

  // sync1 != sync2 means sync2 changes on this edge, so the next value starts a fresh run
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt <= '0;
    end else if ((sync2 == kdata) || commit || (sync1 != sync2)) begin
      cnt <= '0;
    end else begin
      cnt <= cnt_inc;
    end
  end
`else
  assign commit = (sync2 != kdata);
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      kdata <= 4'hF;
    end else if (commit) begin
      kdata <= sync2;
    end
  end

  // A commit wins over any clear; a same-edge KDATA read counts as consuming the old value.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rdy <= 1'b0;
      ovr <= 1'b0;
      ie  <= 1'b0;
    end else begin
      if (commit) begin
        rdy <= 1'b1;
      end else if (rd_kdata || (wr_kctrl && !dbus[0])) begin
        rdy <= 1'b0;
      end
      if (commit && rdy && !rd_kdata) begin
        ovr <= 1'b1;
      end else if (wr_kctrl && !dbus[1]) begin
        ovr <= 1'b0;
      end
      if (wr_kctrl) begin
        ie <= dbus[8];
      end
    end
  end

  always_comb begin
    rdata = '0;
    if (rd_kdata) begin
      rdata[3:0] = kdata;
    end else if (rd_kctrl) begin
      rdata[8] = ie;
      rdata[1] = ovr;
      rdata[0] = rdy;
    end
  end

  assign dbus        = (!reset && (rd_kdata || rd_kctrl)) ? rdata : {DBITS{1'bz}};
  assign intr        = ie & rdy;
  assign unused_bits = ^{dbus[DBITS-1:9], dbus[7:2]};

endmodule

// File: tb/tb_key_device.sv
// Scoreboarded random/directed bench for key_device; expectations come from a sample-window reference model.
module tb_key_device;

  localparam int          DB    = 4;
  localparam logic [31:0] AK    = 32'hF0000010;
  localparam logic [31:0] AC    = 32'hF0000110;
  localparam logic [31:0] AX    = 32'hF0000000;
  // The bus carries pull-ups, so an undriven bus reads all ones.
  localparam logic [31:0] FLOAT = 32'hFFFF_FFFF;
`ifdef KEY_DEBOUNCE_EN
  localparam int WIN = DB;
`else
  localparam int WIN = 1;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] abus;
  logic [31:0] wdat;
  logic        we;
  logic [3:0]  key;
  wire  [31:0] dbus;
  wire         intr;

  assign dbus = we ? wdat : 32'hzzzz_zzzz;
  for (genvar g = 0; g < 32; g++) begin : g_pu
    pullup (dbus[g]);
  end

  key_device #(
    .DBITS(32), .ADDR_KDATA(AK), .ADDR_KCTRL(AC), .DEBOUNCE_CYCLES(DB)
  ) dut (
    .clk(clk), .reset(reset), .abus(abus), .dbus(dbus),
    .we(we), .key(key), .intr(intr)
  );

  always #5 clk = ~clk;

  logic [3:0]  m_kdata;
  bit          m_rdy, m_ovr, m_ie;
  logic [3:0]  hist[$];
  logic [31:0] q_d[$];
  bit          q_i[$];
  string       q_tag[$];
  string       cur_tag = "reset";
  int          n_chk = 0;
  int          n_pass = 0;

  function automatic void model_reset();
    hist.delete();
    for (int i = 0; i < WIN + 2; i++) hist.push_back(4'hF);
    m_kdata = 4'hF;
    m_rdy = 1'b0;
    m_ovr = 1'b0;
    m_ie  = 1'b0;
  endfunction

  // kdata takes a value once the last WIN synchronized samples (two edges old) all agree on it.
  function automatic void model_edge();
    bit agree, commit, rd, wr, old_rdy;
    logic [3:0] v;
    hist.push_front(key);
    if (hist.size() > WIN + 2) void'(hist.pop_back());
    v = hist[2];
    agree = 1'b1;
    for (int i = 2; i < WIN + 2; i++) if (hist[i] != v) agree = 1'b0;
    commit  = agree && (v != m_kdata);
    rd      = (abus == AK) && !we;
    wr      = (abus == AC) && we;
    old_rdy = m_rdy;
    if (wr) m_ie = wdat[8];
    if (commit) m_rdy = 1'b1;
    else if (rd || (wr && !wdat[0])) m_rdy = 1'b0;
    if (commit && old_rdy && !rd) m_ovr = 1'b1;
    else if (wr && !wdat[1]) m_ovr = 1'b0;
    if (commit) m_kdata = v;
  endfunction

  function automatic void push_exp();
    logic [31:0] d;
    d = FLOAT;
    if (we) d = wdat;
    else if (!reset && abus == AK) d = {28'b0, m_kdata};
    else if (!reset && abus == AC) d = {23'b0, m_ie, 6'b0, m_ovr, m_rdy};
    q_d.push_back(d);
    q_i.push_back(!reset && m_ie && m_rdy);
    q_tag.push_back(cur_tag);
  endfunction

  task automatic cyc(input logic [3:0] k, input logic [31:0] a, input logic w, input logic [31:0] d);
    @(posedge clk);
    #1;
    if (!reset) model_edge();
    key  = k;
    abus = a;
    we   = w;
    wdat = d;
    push_exp();
  endtask

  task automatic do_reset(input logic [3:0] k);
    @(posedge clk);
    #1;
    if (!reset) model_edge();
    reset = 1'b1;
    model_reset();
    key  = k;
    abus = AK;
    we   = 1'b0;
    push_exp();
    @(posedge clk);
    #1;
    abus = AC;
    push_exp();
    @(posedge clk);
    #1;
    reset = 1'b0;
    abus  = AX;
    push_exp();
  endtask

  always @(negedge clk) begin
    if (q_d.size() > 0) begin : mon
      logic [31:0] ed;
      bit          ei;
      string       t;
      ed = q_d.pop_front();
      ei = q_i.pop_front();
      t  = q_tag.pop_front();
      n_chk++;
      if (dbus === ed) n_pass++;
      else $display("FAIL %s dbus: got %h, expected %h", t, dbus, ed);
      n_chk++;
      if (intr === ei) n_pass++;
      else $display("FAIL %s intr: got %b, expected %b", t, intr, ei);
    end
  end

  initial begin
    int          hold;
    logic [3:0]  kv;
    logic [31:0] a, d;
    int          op;
    reset = 1'b1;
    key   = 4'hF;
    abus  = AX;
    we    = 1'b0;
    wdat  = '0;
    model_reset();
    do_reset(4'hF);

    cur_tag = "rst_kdata";  cyc(4'hF, AK, 1'b0, 0);
    cur_tag = "rst_kctrl";  cyc(4'hF, AC, 1'b0, 0);
    cur_tag = "rst_float";  cyc(4'hF, AX, 1'b0, 0);

    cur_tag = "commit_e";   repeat (WIN + 4) cyc(4'hE, AC, 1'b0, 0);
    cur_tag = "rd_kdata";   cyc(4'hE, AK, 1'b0, 0);
    cur_tag = "rdy_clr";    cyc(4'hE, AC, 1'b0, 0);

    cur_tag = "bounce";
    for (int i = 0; i < 20; i++) cyc(((i / 2) % 2) != 0 ? 4'hF : 4'hE, AC, 1'b0, 0);
    cur_tag = "settle";     repeat (WIN + 4) cyc(4'hF, AC, 1'b0, 0);
    cyc(4'hF, AK, 1'b0, 0);

    cur_tag = "two_commits";
    repeat (WIN + 4) cyc(4'hE, AX, 1'b0, 0);
    repeat (WIN + 4) cyc(4'hF, AX, 1'b0, 0);
    cyc(4'hF, AC, 1'b0, 0);
    cur_tag = "kctrl_wr";   cyc(4'hF, AC, 1'b1, 32'h100);
    cyc(4'hF, AC, 1'b0, 0);
    cur_tag = "intr";       repeat (WIN + 4) cyc(4'hE, AC, 1'b0, 0);

    cur_tag = "same_edge";
    cyc(4'hE, AC, 1'b1, 32'h101);
    for (int i = 0; i < WIN + 1; i++) cyc(4'hD, AX, 1'b0, 0);
    cyc(4'hD, AK, 1'b0, 0);
    cyc(4'hD, AC, 1'b0, 0);

    cur_tag = "wr_kdata";   cyc(4'hD, AK, 1'b1, 32'h5);
    cyc(4'hD, AK, 1'b0, 0);

    cur_tag = "pend_rst";
    cyc(4'h7, AX, 1'b0, 0);
    do_reset(4'hF);
    cur_tag = "post_rst";
    cyc(4'hF, AK, 1'b0, 0);
    cyc(4'hF, AC, 1'b0, 0);

    cur_tag = "random";
    hold = 0;
    kv   = 4'hF;
    for (int n = 0; n < 1500; n++) begin
      if (hold == 0) begin
        kv   = 4'($urandom_range(0, 15));
        hold = $urandom_range(1, WIN + 6);
      end
      hold--;
      op = $urandom_range(0, 9);
      d  = $urandom;
      a  = $urandom;
      if (a == AK || a == AC) a = AX;
      case (op)
        0, 1, 2: cyc(kv, a,  1'b0, 0);
        3, 4:    cyc(kv, AK, 1'b0, 0);
        5, 6:    cyc(kv, AC, 1'b0, 0);
        7:       cyc(kv, AC, 1'b1, d);
        8:       cyc(kv, AK, 1'b1, d);
        default: cyc(kv, a,  1'b1, d);
      endcase
      if ($urandom_range(0, 299) == 0) do_reset(kv);
    end

    @(posedge clk);
    #1;
    abus = AX;
    we   = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    if (q_d.size() != 0) begin
      n_chk++;
      $display("FAIL drain: %0d expectations left, expected 0", q_d.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
